fm_bram_loader: RTL and testbench
=================================

// Module: fm_bram_loader
// PURPOSE
//  Write side of the per-PE input feature-map BRAMs read by the layer block.
//  Accepts the input FM as a raster pixel stream (valid/ready), one channel frame after another.
//  Each pixel goes to the bank and lane that the layer block later reads for that row and channel.
//  Pulses o_done when all IN_FM_CH frames are stored. The layer block may then be started.
// PARAMETERS
//  FM_SIZE   8   input FM width = height (pixels)
//  IN_FM_CH  2   channel frames per load; one BRAM lane per channel
//  ROW_STEP  3   rows owned by each non-last bank (= ROW_NUM-(KERNEL_SIZE-STRIDE))
//  BRAM_NUM  3   number of FM banks; last bank owns rows (BRAM_NUM-1)*ROW_STEP .. FM_SIZE-1
//  DW        30  pixel width (A_DSP_WIDTH)
//  localparam LAST_ROWS = FM_SIZE-(BRAM_NUM-1)*ROW_STEP
//  localparam AW = $clog2(max(ROW_STEP,LAST_ROWS)*FM_SIZE)
// PORTS
//  i_clk       in   1              clock
//  i_rst       in   1              synchronous, active-high reset
//  i_start     in   1              begin a load (sampled in IDLE only)
//  i_valid     in   1              stream pixel valid
//  i_data      in   DW             stream pixel, row-major, channel-major frames
//  i_last      in   1              asserted with the final pixel of each channel frame
//  o_ready     out  1              loader accepts a pixel this cycle
//  o_bram_w_en out  BRAM_NUM*IN_FM_CH  one-hot lane write enable, bit = bank*IN_FM_CH+ch
//  o_bram_w_addr out AW            word address within bank
//  o_bram_w_data out DW            pixel data, broadcast to all lanes
//  o_busy      out  1              high from accepted i_start until o_done
//  o_done      out  1              one-cycle pulse after the last write
//  o_err       out  1              sticky: i_last mismatch seen; cleared by i_start/reset
// BEHAVIOUR
//  Reset: state IDLE; o_ready=0, o_bram_w_en=0, addr=0, data=0, o_busy=0, o_done=0, o_err=0.
//  FSM IDLE -> LOAD on i_start. LOAD -> DONE on the beat that accepts the last pixel of ch IN_FM_CH-1.
//  DONE -> IDLE after one cycle. o_done=1 in DONE only.
//  o_ready=1 exactly in LOAD. Beat = i_valid&&o_ready. i_valid without o_ready is ignored.
//  Counters col(0..FM_SIZE-1), lrow, bank, ch are zeroed on entry to LOAD.
//  Each beat: col++; on wrap col=0 and the row advances.
//  Row advance: lrow++. If lrow==ROW_STEP-1 and bank<BRAM_NUM-1: lrow=0, bank++.
//  Last bank: lrow keeps counting up to LAST_ROWS-1.
//  Frame end (col=FM_SIZE-1, bank=BRAM_NUM-1, lrow=LAST_ROWS-1): lrow=bank=0, ch++.
//  Write latency 1 cycle, registered: the cycle after a beat,
//   o_bram_w_en has only bit bank*IN_FM_CH+ch set, o_bram_w_addr=lrow*FM_SIZE+col, data=i_data.
//  o_bram_w_en is 0 in every cycle not following a beat.
//  Address arithmetic is unsigned and never exceeds AW. No overlap duplication:
//   the layer block fetches overlap rows from bank+1 through its mux.
//  i_last check: on every beat, i_last must equal the frame-end condition.
//   On mismatch set o_err; pixel placement is unchanged (counters rule, not i_last).
//  i_start in LOAD/DONE is ignored. i_rst in LOAD aborts: outputs return to reset values next cycle.
//  Partial bank contents are left as written.
//  Simultaneous final beat and i_start: final write issued, DONE entered, i_start dropped.
//  Degenerate BRAM_NUM=1: single bank, LAST_ROWS=FM_SIZE.
// STRUCTURE
//  Shared package (cnn_pkg): DW/A_DSP_WIDTH, ROW_STEP/LAST_ROWS derivation functions,
//   and the FSM state encoding for the loader.
//   The layer block derives the same values from the same functions.
//  One natural sub-module: fm_raster_counter (col/lrow/bank/ch with frame-end flag).
//  The FSM, registered write port and i_last checker stay in this top level.
// TESTING (FM_SIZE=8, IN_FM_CH=2, ROW_STEP=3, BRAM_NUM=3 unless noted)
//  Full load, i_valid always 1: 128 writes; pixel r4 c5 ch1 -> en bit3, addr13.
//   Pixel r7 c7 ch0 -> bit4, addr15. o_done pulses 1 cycle after the 128th write.
//  Random i_valid bubbles: same 128 (en,addr,data) tuples in order; no write in bubble cycles.
//  i_last asserted at beat 63 only (missing at 127): o_err=1 after beat 127. Placement identical.
//   The next i_start clears o_err.
//  i_rst at beat 40: next cycle all outputs 0, IDLE. A new full load completes with 128 correct writes.
//  i_start pulsed during LOAD and coincident with the final beat: no restart.
//   Exactly one o_done. o_busy falls with o_done.
//  BRAM_NUM=1, FM_SIZE=4, IN_FM_CH=1: 16 writes to en bit0, addr 0..15 in order.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: datapath width, bank geometry
// helpers and the input feature-map loader state encoding.
package cnn_pkg;

  localparam int A_DSP_WIDTH = 30;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int row_step(input int row_num, input int kernel,
                                  input int stride);
    return row_num - (kernel - stride);
  endfunction

  function automatic int last_rows(input int fm, input int step,
                                   input int banks);
    return fm - (banks - 1) * step;
  endfunction

  function automatic int bank_rows(input int fm, input int step,
                                   input int banks);
    int lr;
    lr = last_rows(fm, step, banks);
    return (step > lr) ? step : lr;
  endfunction

  function automatic int fm_aw(input int fm, input int step,
                               input int banks);
    return cw(bank_rows(fm, step, banks) * fm);
  endfunction

endpackage

// File: rtl/fm_raster_counter.sv
// Raster position tracker for the FM loader: column, row within bank,
// bank and channel, with a flag marking the last pixel of a frame.
module fm_raster_counter
  import cnn_pkg::*;
#(
  parameter int FM_SIZE  = 8,
  parameter int IN_FM_CH = 2,
  parameter int ROW_STEP = 3,
  parameter int BRAM_NUM = 3,
  localparam int CW  = cw(FM_SIZE),
  localparam int LRW = cw(bank_rows(FM_SIZE, ROW_STEP, BRAM_NUM)),
  localparam int BW  = cw(BRAM_NUM),
  localparam int HW  = cw(IN_FM_CH)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clr,
  input  logic           i_step,
  output logic [CW-1:0]  o_col,
  output logic [LRW-1:0] o_lrow,
  output logic [BW-1:0]  o_bank,
  output logic [HW-1:0]  o_ch,
  output logic           o_frame_end,
  output logic           o_last_ch
);

  localparam int LAST_ROWS = last_rows(FM_SIZE, ROW_STEP, BRAM_NUM);
  localparam logic [CW-1:0]  COL_MAX  = CW'(FM_SIZE - 1);
  localparam logic [LRW-1:0] STEP_MAX = LRW'(ROW_STEP - 1);
  localparam logic [LRW-1:0] LAST_MAX = LRW'(LAST_ROWS - 1);
  localparam logic [BW-1:0]  BANK_MAX = BW'(BRAM_NUM - 1);
  localparam logic [HW-1:0]  CH_MAX   = HW'(IN_FM_CH - 1);

  logic [CW-1:0]  col_q, col_d;
  logic [LRW-1:0] lrow_q, lrow_d;
  logic [BW-1:0]  bank_q, bank_d;
  logic [HW-1:0]  ch_q, ch_d;
  logic           frame_end;

  assign frame_end = (col_q == COL_MAX) && (bank_q == BANK_MAX) &&
                     (lrow_q == LAST_MAX);

  // Next raster position: column wraps into row, row into bank, frame into channel
  always_comb begin
    col_d  = col_q;
    lrow_d = lrow_q;
    bank_d = bank_q;
    ch_d   = ch_q;
    if (i_clr) begin
      col_d  = '0;
      lrow_d = '0;
      bank_d = '0;
      ch_d   = '0;
    end else if (i_step) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        if (frame_end) begin
          lrow_d = '0;
          bank_d = '0;
          ch_d   = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
        end else if ((lrow_q == STEP_MAX) && (bank_q != BANK_MAX)) begin
          lrow_d = '0;
          bank_d = bank_q + 1'b1;
        end else begin
          lrow_d = lrow_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q  <= '0;
      lrow_q <= '0;
      bank_q <= '0;
      ch_q   <= '0;
    end else begin
      col_q  <= col_d;
      lrow_q <= lrow_d;
      bank_q <= bank_d;
      ch_q   <= ch_d;
    end
  end

  assign o_col       = col_q;
  assign o_lrow      = lrow_q;
  assign o_bank      = bank_q;
  assign o_ch        = ch_q;
  assign o_frame_end = frame_end;
  assign o_last_ch   = (ch_q == CH_MAX);

endmodule

// File: rtl/fm_bram_loader.sv
// Input FM loader: steers a raster pixel stream into per-bank,
// per-channel BRAM lanes and signals completion to the layer block.
module fm_bram_loader
  import cnn_pkg::*;
#(
  parameter int FM_SIZE  = 8,
  parameter int IN_FM_CH = 2,
  parameter int ROW_STEP = 3,
  parameter int BRAM_NUM = 3,
  parameter int DW       = A_DSP_WIDTH,
  localparam int NL = BRAM_NUM * IN_FM_CH,
  localparam int AW = fm_aw(FM_SIZE, ROW_STEP, BRAM_NUM)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  output logic          o_ready,
  output logic [NL-1:0] o_bram_w_en,
  output logic [AW-1:0] o_bram_w_addr,
  output logic [DW-1:0] o_bram_w_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int CW  = cw(FM_SIZE);
  localparam int LRW = cw(bank_rows(FM_SIZE, ROW_STEP, BRAM_NUM));
  localparam int BW  = cw(BRAM_NUM);
  localparam int HW  = cw(IN_FM_CH);
  localparam int LW  = cw(NL);

  ld_state_e      state_q, state_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [NL-1:0]  en_q, en_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;

  logic           beat;
  logic           start_ok;
  logic [CW-1:0]  col;
  logic [LRW-1:0] lrow;
  logic [BW-1:0]  bank;
  logic [HW-1:0]  ch;
  logic           frame_end;
  logic           last_ch;
  logic [LW-1:0]  lane;

  assign beat     = i_valid && ready_q;
  assign start_ok = (state_q == LD_IDLE) && i_start;

  fm_raster_counter #(
    .FM_SIZE  (FM_SIZE),
    .IN_FM_CH (IN_FM_CH),
    .ROW_STEP (ROW_STEP),
    .BRAM_NUM (BRAM_NUM)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (start_ok),
    .i_step      (beat),
    .o_col       (col),
    .o_lrow      (lrow),
    .o_bank      (bank),
    .o_ch        (ch),
    .o_frame_end (frame_end),
    .o_last_ch   (last_ch)
  );

  assign lane = LW'(bank) * LW'(IN_FM_CH) + LW'(ch);

  // Next state, write port contents and i_last consistency tracking
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE: if (i_start) state_d = LD_LOAD;
      LD_LOAD: if (beat && frame_end && last_ch) state_d = LD_DONE;
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
    ready_d = (state_d == LD_LOAD);
    busy_d  = (state_d == LD_LOAD);
    done_d  = (state_d == LD_DONE);
    err_d   = start_ok ? 1'b0 : (err_q || (beat && (i_last != frame_end)));
    en_d    = beat ? (NL'(1) << lane) : '0;
    addr_d  = beat ? (AW'(lrow) * AW'(FM_SIZE) + AW'(col)) : addr_q;
    data_d  = beat ? i_data : data_q;
  end

  // FSM state and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= LD_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_bram_w_en   = en_q;
  assign o_bram_w_addr = addr_q;
  assign o_bram_w_data = data_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_fm_bram_loader.sv
// Bench for fm_bram_loader: scoreboarded full loads with bubbles,
// i_last errors, aborts, restart attempts and a single-bank variant.
module tb_fm_bram_loader;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [29:0] i_data = '0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic [5:0]  o_bram_w_en;
  logic [4:0]  o_bram_w_addr;
  logic [29:0] o_bram_w_data;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  logic        s_start = 1'b0;
  logic        s_valid = 1'b0;
  logic [29:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [0:0]  s_en;
  logic [3:0]  s_addr;
  logic [29:0] s_wdata;
  logic        s_busy;
  logic        s_done;
  logic        s_err;

  always #5 clk = ~clk;

  fm_bram_loader #(
    .FM_SIZE(8), .IN_FM_CH(2), .ROW_STEP(3), .BRAM_NUM(3), .DW(30)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid),
    .i_data(i_data), .i_last(i_last), .o_ready(o_ready),
    .o_bram_w_en(o_bram_w_en), .o_bram_w_addr(o_bram_w_addr),
    .o_bram_w_data(o_bram_w_data), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err)
  );

  fm_bram_loader #(
    .FM_SIZE(4), .IN_FM_CH(1), .ROW_STEP(4), .BRAM_NUM(1), .DW(30)
  ) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_start(s_start), .i_valid(s_valid),
    .i_data(s_data), .i_last(s_last), .o_ready(s_ready),
    .o_bram_w_en(s_en), .o_bram_w_addr(s_addr),
    .o_bram_w_data(s_wdata), .o_busy(s_busy), .o_done(s_done),
    .o_err(s_err)
  );

  typedef struct {
    logic [5:0]  en;
    logic [4:0]  addr;
    logic [29:0] data;
    bit          last;
  } exp_t;

  typedef struct {
    int row;
    int col;
    int ch;
    int bitn;
    int addr;
  } vec_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          drv_beat = 1'b0;
  int          done_cnt = 0;
  logic [5:0]  cap_en[128];
  logic [4:0]  cap_addr[128];
  int          cap_n = 0;
  vec_t        tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int idx, input int ld);
    exp_t e;
    int ch, p, r, c, bank, lrow;
    ch = idx / 64;
    p = idx % 64;
    r = p / 8;
    c = p % 8;
    bank = r / 3;
    if (bank > 2) bank = 2;
    lrow = r - bank * 3;
    e.en = 6'(1 << (bank * 2 + ch));
    e.addr = 5'(lrow * 8 + c);
    e.data = 30'(ld * 1000 + idx * 37 + 11);
    e.last = (idx == 127);
    return e;
  endfunction

  // Write-port monitor against the scoreboard
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (drv_beat) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("wr_en", 32'(o_bram_w_en), 32'(e.en));
        chk("wr_addr", 32'(o_bram_w_addr), 32'(e.addr));
        chk("wr_data", 32'(o_bram_w_data), 32'(e.data));
        chk("done_at_last", 32'(o_done), 32'(e.last));
        if (e.last) chk("busy_at_done", 32'(o_busy), 32'd0);
        if (cap_n < 128) begin
          cap_en[cap_n] = o_bram_w_en;
          cap_addr[cap_n] = o_bram_w_addr;
          cap_n++;
        end
      end
    end else begin
      chk("no_wr", 32'(o_bram_w_en), 32'd0);
      chk("no_done", 32'(o_done), 32'd0);
    end
    if (o_done) done_cnt++;
  end

  task automatic run_load(input int ld, input bit bub, input bit miss,
                          input int rst_at, input bit poke);
    int idx;
    int cyc;
    int d0;
    bit b;
    idx = 0;
    cyc = 0;
    d0 = done_cnt;
    cap_n = 0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("err_clr_on_start", 32'(o_err), 32'd0);
    chk("busy_in_load", 32'(o_busy), 32'd1);
    while (idx < 128 && cyc < 3000) begin
      i_valid = bub ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_data = 30'(ld * 1000 + idx * 37 + 11);
      i_last = (idx == 63) || (idx == 127 && !miss);
      i_start = poke && (idx == 20 || idx == 127);
      if (idx == rst_at) begin
        i_rst = 1'b1;
        i_valid = 1'b1;
      end
      b = i_valid && o_ready && !i_rst;
      drv_beat = b;
      if (b) begin
        sbq.push_back(model(idx, ld));
        idx++;
      end
      @(negedge clk);
      cyc++;
      if (i_rst) begin
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_en", 32'(o_bram_w_en), 32'd0);
        chk("rst_addr", 32'(o_bram_w_addr), 32'd0);
        chk("rst_data", 32'(o_bram_w_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        i_rst = 1'b0;
        i_valid = 1'b0;
        i_last = 1'b0;
        drv_beat = 1'b0;
        return;
      end
    end
    chk("load_beats", 32'(idx), 32'd128);
    i_start = poke;
    i_valid = 1'b0;
    i_last = 1'b0;
    drv_beat = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_ready", 32'(o_ready), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("err_after_load", 32'(o_err), 32'(miss));
  endtask

  initial begin
    tbl[0] = '{4, 5, 1, 3, 13};
    tbl[1] = '{7, 7, 0, 4, 15};
    tbl[2] = '{0, 0, 0, 0, 0};
    tbl[3] = '{2, 7, 0, 0, 23};
    tbl[4] = '{3, 0, 0, 2, 0};
    tbl[5] = '{5, 7, 1, 3, 23};
    tbl[6] = '{6, 0, 1, 5, 0};
    tbl[7] = '{7, 7, 1, 5, 15};

    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(o_ready), 32'd0);
    chk("reset_en", 32'(o_bram_w_en), 32'd0);
    chk("reset_addr", 32'(o_bram_w_addr), 32'd0);
    chk("reset_data", 32'(o_bram_w_data), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_err", 32'(o_err), 32'd0);

    run_load(1, 1'b0, 1'b0, -1, 1'b0);
    chk("cap_count", 32'(cap_n), 32'd128);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = tbl[i].ch * 64 + tbl[i].row * 8 + tbl[i].col;
      chk("tbl_en", 32'(cap_en[k]), 32'(1 << tbl[i].bitn));
      chk("tbl_addr", 32'(cap_addr[k]), 32'(tbl[i].addr));
    end

    run_load(2, 1'b1, 1'b0, -1, 1'b0);
    run_load(3, 1'b0, 1'b1, -1, 1'b0);
    run_load(4, 1'b1, 1'b0, 40, 1'b0);
    chk("sb_empty_after_abort", 32'(sbq.size()), 32'd0);
    run_load(5, 1'b0, 1'b0, -1, 1'b0);
    run_load(6, 1'b0, 1'b0, -1, 1'b1);

    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      s_valid = 1'b1;
      s_data = 30'(k + 500);
      s_last = (k == 15);
      @(posedge clk);
      #1;
      chk("s_en", 32'(s_en), 32'd1);
      chk("s_addr", 32'(s_addr), 32'(k));
      chk("s_data", 32'(s_wdata), 32'(k + 500));
      chk("s_done", 32'(s_done), 32'(k == 15));
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    @(negedge clk);
    chk("s_idle_en", 32'(s_en), 32'd0);
    chk("s_idle_busy", 32'(s_busy), 32'd0);
    chk("s_err", 32'(s_err), 32'd0);
    chk("s_ready", 32'(s_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
